// File: rtl/fifo_defs_pkg.sv
// rtl/fifo_defs_pkg.sv - shared FIFO helpers and read-mode constants
package fifo_defs_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Elaboration-time ceil(log2(value)); value <= 1 yields 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - WIDTH x DEPTH register array, sync write, async read
module fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - single-clock FIFO with count, thresholds, sticky errors, optional FWFT
module sync_fifo_ctrl
    import fifo_defs_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int FWFT  = FIFO_MODE_STD
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    write,
    input  logic                    read,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        dout,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [clog2(DEPTH):0]   count,
    input  logic [clog2(DEPTH):0]   af_thresh,
    input  logic [clog2(DEPTH):0]   ae_thresh,
    output logic                    overflow,
    output logic                    underflow,
    input  logic                    clr_err
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr, rd_ptr;
    logic [AW:0]      wr_ptr_nxt, rd_ptr_nxt;
    logic [AW:0]      count_nxt;
    logic             wr_ok, rd_ok;
    logic [WIDTH-1:0] ram_rdata;

    // Full/empty block the request outright; the other side never rescues it.
    assign wr_ok = write && !full;
    assign rd_ok = read && !empty;

    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        if (wr_ok) begin
            wr_ptr_nxt = wr_ptr + ONE;
        end
        if (rd_ok) begin
            rd_ptr_nxt = rd_ptr + ONE;
        end
        case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count + ONE;
            2'b01:   count_nxt = count - ONE;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            empty  <= (wr_ptr_nxt == rd_ptr_nxt);
            full   <= (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                      (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
        end
    end

    // A new error on the same edge wins over the clear request.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write && full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (read && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    assign almost_full  = (af_thresh == '0) || (count >= af_thresh);
    assign almost_empty = (count <= ae_thresh);

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (din),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (ram_rdata)
    );

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            assign dout = ram_rdata;
        end else begin : g_std
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    dout <= '0;
                end else if (rd_ok) begin
                    dout <= ram_rdata;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb/tb_sync_fifo_ctrl.sv - randomized self-checking bench, standard and FWFT builds side by side
module tb_sync_fifo_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             write = 1'b0;
    logic             read = 1'b0;
    logic             clr_err = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic [CW-1:0]    af_thresh = 5'd12;
    logic [CW-1:0]    ae_thresh = 5'd3;

    logic [WIDTH-1:0] dout0, dout1;
    logic             empty0, full0, af0, ae0, ov0, uf0;
    logic             empty1, full1, af1, ae1, ov1, uf1;
    logic [CW-1:0]    count0, count1;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] exp_dout;
    logic             exp_ov, exp_uf;

    always #5 clk = ~clk;

    sync_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(0)) dut_std (
        .clk(clk), .rstn(rstn), .write(write), .read(read), .din(din), .dout(dout0),
        .empty(empty0), .full(full0), .almost_full(af0), .almost_empty(ae0), .count(count0),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .overflow(ov0), .underflow(uf0),
        .clr_err(clr_err)
    );

    sync_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1)) dut_fwft (
        .clk(clk), .rstn(rstn), .write(write), .read(read), .din(din), .dout(dout1),
        .empty(empty1), .full(full1), .almost_full(af1), .almost_empty(ae1), .count(count1),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .overflow(ov1), .underflow(uf1),
        .clr_err(clr_err)
    );

    // Reference: a queue of stored words; acceptance judged on occupancy before the edge.
    task automatic step();
        bit was_full, was_empty;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        @(posedge clk);
        if (read && !was_empty) exp_dout = q.pop_front();
        if (write && !was_full) q.push_back(din);
        exp_ov = (write && was_full) ? 1'b1 : (clr_err ? 1'b0 : exp_ov);
        exp_uf = (read && was_empty) ? 1'b1 : (clr_err ? 1'b0 : exp_uf);
        #1;
    endtask

    task automatic idle_inputs();
        write = 1'b0; read = 1'b0; clr_err = 1'b0; din = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        idle_inputs();
        q.delete();
        exp_dout = '0; exp_ov = 1'b0; exp_uf = 1'b0;
        #2;
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [WIDTH-1:0] value);
        write = 1'b1; read = 1'b0; din = value;
        step();
        write = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (count0 !== 5'd0 || empty0 !== 1'b1 || full0 !== 1'b0) begin
            bad++; $display("FAIL reset_std_state count=%0d empty=%b full=%b want 0/1/0", count0, empty0, full0);
        end
        total++;
        if (ov0 !== 1'b0 || uf0 !== 1'b0 || dout0 !== 8'h00) begin
            bad++; $display("FAIL reset_std_err_dout ov=%b uf=%b dout=%h want 0/0/00", ov0, uf0, dout0);
        end
        total++;
        if (count1 !== 5'd0 || empty1 !== 1'b1 || ov1 !== 1'b0 || uf1 !== 1'b0) begin
            bad++; $display("FAIL reset_fwft count=%0d empty=%b ov=%b uf=%b want 0/1/0/0", count1, empty1, ov1, uf1);
        end
        total++;
        if (af0 !== 1'b0 || ae0 !== 1'b1) begin
            bad++; $display("FAIL reset_almost af=%b ae=%b want 0/1", af0, ae0);
        end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            push_word(WIDTH'(i));
            total++;
            if (count0 !== CW'(i + 1) || count1 !== CW'(i + 1)) begin
                bad++; $display("FAIL fill_count i=%0d got %0d/%0d want %0d", i, count0, count1, i + 1);
            end
        end
        total++;
        if (full0 !== 1'b1 || full1 !== 1'b1 || count0 !== 5'd16) begin
            bad++; $display("FAIL fill_full full=%b/%b count=%0d want 1/1/16", full0, full1, count0);
        end
        push_word(8'hAA);
        total++;
        if (ov0 !== 1'b1 || ov1 !== 1'b1 || count0 !== 5'd16 || count1 !== 5'd16) begin
            bad++; $display("FAIL overflow ov=%b/%b count=%0d/%0d want 1/1/16/16", ov0, ov1, count0, count1);
        end
    endtask

    task automatic test_drain_underflow();
        for (int i = 0; i < DEPTH; i++) begin
            total++;
            if (dout1 !== WIDTH'(i)) begin
                bad++; $display("FAIL fwft_head i=%0d got %h want %h", i, dout1, WIDTH'(i));
            end
            read = 1'b1;
            step();
            read = 1'b0;
            total++;
            if (dout0 !== WIDTH'(i) || dout0 !== exp_dout) begin
                bad++; $display("FAIL drain_dout i=%0d got %h want %h", i, dout0, WIDTH'(i));
            end
        end
        total++;
        if (empty0 !== 1'b1 || empty1 !== 1'b1 || count0 !== 5'd0) begin
            bad++; $display("FAIL drain_empty empty=%b/%b count=%0d want 1/1/0", empty0, empty1, count0);
        end
        read = 1'b1;
        step();
        read = 1'b0;
        total++;
        if (uf0 !== 1'b1 || uf1 !== 1'b1 || dout0 !== 8'h0F) begin
            bad++; $display("FAIL underflow uf=%b/%b dout=%h want 1/1/0f", uf0, uf1, dout0);
        end
        total++;
        if (ov0 !== 1'b1) begin
            bad++; $display("FAIL overflow_sticky ov=%b want 1", ov0);
        end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        total++;
        if (ov0 !== 1'b0 || uf0 !== 1'b0 || ov1 !== 1'b0 || uf1 !== 1'b0) begin
            bad++; $display("FAIL clr_err ov=%b/%b uf=%b/%b want 0", ov0, ov1, uf0, uf1);
        end
    endtask

    task automatic test_wrap();
        int written;
        logic [WIDTH-1:0] next_read;
        do_reset();
        written = 0;
        next_read = 8'h30;
        for (int cyc = 0; cyc < 200 && (written < 40 || q.size() > 0); cyc++) begin
            write = (written < 40) && (q.size() < 5);
            read  = (q.size() > 1) || (written == 40 && q.size() > 0);
            din   = WIDTH'(8'h30 + written);
            if (write) written++;
            step();
            if (read) begin
                total++;
                if (dout0 !== next_read) begin
                    bad++; $display("FAIL wrap_data got %h want %h", dout0, next_read);
                end
                next_read++;
            end
            total++;
            if (count0 > 5'd5 || count0 !== CW'(q.size()) || ov0 || uf0) begin
                bad++; $display("FAIL wrap_state count=%0d want %0d ov=%b uf=%b", count0, q.size(), ov0, uf0);
            end
        end
        idle_inputs();
        total++;
        if (next_read !== 8'h58) begin
            bad++; $display("FAIL wrap_total last=%h want 58", next_read);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < 8; i++) push_word(8'h80 + WIDTH'(i));
        write = 1'b1; read = 1'b1; din = 8'hC0;
        step();
        idle_inputs();
        total++;
        if (count0 !== 5'd8 || count1 !== 5'd8 || dout0 !== 8'h80 || dout1 !== 8'h81) begin
            bad++; $display("FAIL rw_mid count=%0d/%0d dout=%h/%h want 8/8/80/81", count0, count1, dout0, dout1);
        end
        do_reset();
        write = 1'b1; read = 1'b1; din = 8'h11;
        step();
        idle_inputs();
        total++;
        if (count0 !== 5'd1 || uf0 !== 1'b1 || ov0 !== 1'b0 || dout1 !== 8'h11) begin
            bad++; $display("FAIL rw_empty count=%0d uf=%b ov=%b head=%h want 1/1/0/11", count0, uf0, ov0, dout1);
        end
        do_reset();
        for (int i = 0; i < DEPTH; i++) push_word(WIDTH'(i));
        write = 1'b1; read = 1'b1; din = 8'hEE;
        step();
        idle_inputs();
        total++;
        if (count0 !== 5'd15 || ov0 !== 1'b1 || uf0 !== 1'b0 || full0 !== 1'b0 || dout0 !== 8'h00) begin
            bad++; $display("FAIL rw_full count=%0d ov=%b uf=%b full=%b dout=%h want 15/1/0/0/00", count0, ov0, uf0, full0, dout0);
        end
    endtask

    task automatic test_thresholds();
        do_reset();
        af_thresh = 5'd12; ae_thresh = 5'd3;
        for (int i = 1; i <= 13; i++) begin
            push_word(WIDTH'(i));
            total++;
            if (af0 !== (i >= 12) || af1 !== (i >= 12) || ae0 !== (i <= 3)) begin
                bad++; $display("FAIL thresh count=%0d af=%b ae=%b want %b/%b", i, af0, ae0, i >= 12, i <= 3);
            end
            if (i == 8) begin
                af_thresh = 5'd5;
                #1;
                total++;
                if (af0 !== 1'b1 || af1 !== 1'b1) begin
                    bad++; $display("FAIL thresh_live af=%b/%b want 1", af0, af1);
                end
                af_thresh = 5'd12;
                #1;
            end
        end
        af_thresh = 5'd0; ae_thresh = 5'd16;
        #1;
        total++;
        if (af0 !== 1'b1 || ae0 !== 1'b1) begin
            bad++; $display("FAIL thresh_force af=%b ae=%b want 1/1", af0, ae0);
        end
        af_thresh = 5'd12; ae_thresh = 5'd3;
    endtask

    task automatic test_fwft();
        do_reset();
        push_word(8'h5A);
        total++;
        if (dout1 !== 8'h5A || empty1 !== 1'b0) begin
            bad++; $display("FAIL fwft_show dout=%h empty=%b want 5a/0", dout1, empty1);
        end
        read = 1'b1;
        step();
        read = 1'b0;
        total++;
        if (empty1 !== 1'b1 || count1 !== 5'd0) begin
            bad++; $display("FAIL fwft_pop empty=%b count=%0d want 1/0", empty1, count1);
        end
        read = 1'b1;
        step();
        read = 1'b0;
        for (int i = 0; i < 7; i++) push_word(WIDTH'(8'h40 + i));
        total++;
        if (count1 !== 5'd7 || uf1 !== 1'b1) begin
            bad++; $display("FAIL pre_reset count=%0d uf=%b want 7/1", count1, uf1);
        end
        #3;
        rstn = 1'b0;
        q.delete(); exp_dout = '0; exp_ov = 1'b0; exp_uf = 1'b0;
        #1;
        total++;
        if (count0 !== 5'd0 || count1 !== 5'd0 || empty0 !== 1'b1 || empty1 !== 1'b1) begin
            bad++; $display("FAIL async_reset count=%0d/%0d empty=%b/%b want 0/0/1/1", count0, count1, empty0, empty1);
        end
        total++;
        if (uf0 !== 1'b0 || uf1 !== 1'b0 || ov1 !== 1'b0 || dout0 !== 8'h00) begin
            bad++; $display("FAIL async_reset_err uf=%b/%b ov=%b dout=%h want 0/0/0/00", uf0, uf1, ov1, dout0);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            write   = ($urandom_range(0, 99) < 55);
            read    = ($urandom_range(0, 99) < 45);
            clr_err = ($urandom_range(0, 99) < 5);
            din     = WIDTH'($urandom);
            if ($urandom_range(0, 19) == 0) af_thresh = CW'($urandom_range(0, 17));
            if ($urandom_range(0, 19) == 0) ae_thresh = CW'($urandom_range(0, 17));
            step();
            total++;
            if (count0 !== CW'(q.size()) || count1 !== CW'(q.size()) ||
                empty0 !== (q.size() == 0) || full0 !== (q.size() == DEPTH) ||
                empty1 !== (q.size() == 0) || full1 !== (q.size() == DEPTH)) begin
                bad++; $display("FAIL rand_occ cyc=%0d count=%0d/%0d empty=%b full=%b want %0d", cyc, count0, count1, empty0, full0, q.size());
            end
            total++;
            if (ov0 !== exp_ov || uf0 !== exp_uf || ov1 !== exp_ov || uf1 !== exp_uf) begin
                bad++; $display("FAIL rand_err cyc=%0d ov=%b/%b uf=%b/%b want %b/%b", cyc, ov0, ov1, uf0, uf1, exp_ov, exp_uf);
            end
            total++;
            if (af0 !== ((af_thresh == 0) || (q.size() >= af_thresh)) || ae0 !== (q.size() <= ae_thresh) ||
                af1 !== af0 || ae1 !== ae0) begin
                bad++; $display("FAIL rand_almost cyc=%0d af=%b ae=%b size=%0d af_t=%0d ae_t=%0d", cyc, af0, ae0, q.size(), af_thresh, ae_thresh);
            end
            total++;
            if (dout0 !== exp_dout) begin
                bad++; $display("FAIL rand_dout cyc=%0d got %h want %h", cyc, dout0, exp_dout);
            end
            if (q.size() > 0) begin
                total++;
                if (dout1 !== q[0]) begin
                    bad++; $display("FAIL rand_fwft cyc=%0d got %h want %h", cyc, dout1, q[0]);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        exp_dout = '0; exp_ov = 1'b0; exp_uf = 1'b0;
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_wrap();
        test_simultaneous();
        test_thresholds();
        test_fwft();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
